// File: rtl/mixer_pkg.sv
// Shared definitions for the quadrature mixer: LO codes, combine modes and
// the internal fs/4 LO tables.
package mixer_pkg;

   // LO codes as carried on the external LO pins (2'b11 also decodes as -1).
   localparam logic [1:0] LO_ZERO = 2'b00;
   localparam logic [1:0] LO_POS  = 2'b01;
   localparam logic [1:0] LO_NEG  = 2'b10;

   // Output combine selection.
   typedef enum logic [1:0] {
      MODE_SUM    = 2'b00,
      MODE_DIFF   = 2'b01,
      MODE_I_ONLY = 2'b10,
      MODE_Q_ONLY = 2'b11
   } mode_e;

   // fs/4 LO tables, entry for phase p sits at bits [2p+1:2p].
   // I: +1, 0, -1, 0    Q: 0, +1, 0, -1
   localparam logic [7:0] LO_I_TABLE = {LO_ZERO, LO_NEG, LO_ZERO, LO_POS};
   localparam logic [7:0] LO_Q_TABLE = {LO_NEG, LO_ZERO, LO_POS, LO_ZERO};

   function automatic logic [1:0] lo_lookup(input logic [7:0] tab, input logic [1:0] p);
      return tab[{p, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/quad_lo_gen.sv
// Internal fs/4 LO: a 2-bit phase counter that steps once per accepted
// sample, with a sync input that reloads the phase. The LO codes reflect
// the phase used by the sample presented in the current cycle.
module quad_lo_gen
   import mixer_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       advance,
   input  logic       sync,
   input  logic [1:0] phase_init,
   output logic [1:0] lo_i,
   output logic [1:0] lo_q
);

   logic [1:0] phase_q;
   logic [1:0] phase_d;
   logic [1:0] phase_use;

   // sync wins over the held phase, so a sample arriving with sync uses phase_init
   always_comb begin
      phase_use = sync ? phase_init : phase_q;
      phase_d   = phase_use;
      if (advance) begin
         phase_d = phase_use + 2'd1;
      end
   end

   // phase register; reset parks it on phase_init
   always_ff @(posedge clock) begin
      if (reset) begin
         phase_q <= phase_init;
      end else begin
         phase_q <= phase_d;
      end
   end

   assign lo_i = lo_lookup(LO_I_TABLE, phase_use);
   assign lo_q = lo_lookup(LO_Q_TABLE, phase_use);

endmodule

// File: rtl/quad_mixer_pipe.sv
// Three-stage quadrature mixer: LO weighting, gain scaling, combine with
// saturation. Fixed 3-cycle latency, no backpressure.
//
// Handshake: in_valid is a one-way strobe with no ready; a sample is taken
// on every rising edge where in_valid=1. out_valid is high for exactly one
// cycle per sample, three cycles after it was taken; out_data/out_sat hold
// their last values while out_valid=0.
module quad_mixer_pipe
   import mixer_pkg::*;
#(
   parameter int          DW       = 15,
   parameter int          GW       = 16,
   parameter logic [GW-1:0] GAIN_RST = 16'h2861
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [DW-1:0] in_i,
   input  logic [DW-1:0] in_q,
   input  logic          lo_sel,
   input  logic [1:0]    lo_i_ext,
   input  logic [1:0]    lo_q_ext,
   input  logic          lo_sync,
   input  logic [1:0]    lo_phase_init,
   input  logic [1:0]    mode,
   input  logic [GW-1:0] gain,
   input  logic          gain_load,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   output logic          out_sat
);

   localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
   localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

   // ---------------- internal LO ----------------
   logic [1:0] gen_lo_i;
   logic [1:0] gen_lo_q;

   quad_lo_gen u_lo_gen (
      .clock      (clock),
      .reset      (reset),
      .advance    (in_valid),
      .sync       (lo_sync),
      .phase_init (lo_phase_init),
      .lo_i       (gen_lo_i),
      .lo_q       (gen_lo_q)
   );

   // ---------------- stage 1: LO weighting ----------------
   logic [1:0]         lo_i_code;
   logic [1:0]         lo_q_code;
   logic signed [DW:0] in_i_ext;
   logic signed [DW:0] in_q_ext;
   logic signed [DW:0] s1_i_d;
   logic signed [DW:0] s1_q_d;
   logic               s1_valid_q;
   logic signed [DW:0] s1_i_q;
   logic signed [DW:0] s1_q_q;
   mode_e              s1_mode_q;

   assign in_i_ext = {in_i[DW-1], in_i};
   assign in_q_ext = {in_q[DW-1], in_q};

   // one extra bit so that negating the most negative input cannot wrap
   always_comb begin
      lo_i_code = lo_sel ? gen_lo_i : lo_i_ext;
      lo_q_code = lo_sel ? gen_lo_q : lo_q_ext;
      s1_i_d    = '0;
      s1_q_d    = '0;
      if (lo_i_code[1]) begin
         s1_i_d = -in_i_ext;
      end else if (lo_i_code[0]) begin
         s1_i_d = in_i_ext;
      end
      if (lo_q_code[1]) begin
         s1_q_d = -in_q_ext;
      end else if (lo_q_code[0]) begin
         s1_q_d = in_q_ext;
      end
   end

   // stage-1 register; mode travels with its sample
   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_i_q     <= '0;
         s1_q_q     <= '0;
         s1_mode_q  <= MODE_SUM;
      end else begin
         s1_valid_q <= in_valid;
         s1_i_q     <= s1_i_d;
         s1_q_q     <= s1_q_d;
         s1_mode_q  <= mode_e'(mode);
      end
   end

   // ---------------- stage 2: gain ----------------
   logic [GW-1:0]             gain_q;
   logic signed [DW+GW+1:0]   prod_i;
   logic signed [DW+GW+1:0]   prod_q;
   logic signed [DW:0]        s2_i_d;
   logic signed [DW:0]        s2_q_d;
   logic                      s2_valid_q;
   logic signed [DW:0]        s2_i_q;
   logic signed [DW:0]        s2_q_q;
   mode_e                     s2_mode_q;
   logic                      unused_prod_bits;

   // active gain; a load affects the sample entering stage 1 in the same cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         gain_q <= GAIN_RST;
      end else if (gain_load) begin
         gain_q <= gain;
      end
   end

   assign prod_i = $signed({{(GW+1){s1_i_q[DW]}}, s1_i_q}) * $signed({{(DW+2){1'b0}}, gain_q});
   assign prod_q = $signed({{(GW+1){s1_q_q[DW]}}, s1_q_q}) * $signed({{(DW+2){1'b0}}, gain_q});

   // dropping the low GW-1 bits of a two's-complement product floors toward -inf;
   // |stage-1| <= 2^(DW-1) and gain < 2.0 keep the result inside DW+1 bits
   assign s2_i_d = prod_i[DW+GW-1:GW-1];
   assign s2_q_d = prod_q[DW+GW-1:GW-1];
   assign unused_prod_bits = ^{prod_i[DW+GW+1:DW+GW], prod_i[GW-2:0],
                               prod_q[DW+GW+1:DW+GW], prod_q[GW-2:0]};

   // stage-2 register
   always_ff @(posedge clock) begin
      if (reset) begin
         s2_valid_q <= 1'b0;
         s2_i_q     <= '0;
         s2_q_q     <= '0;
         s2_mode_q  <= MODE_SUM;
      end else begin
         s2_valid_q <= s1_valid_q;
         s2_i_q     <= s2_i_d;
         s2_q_q     <= s2_q_d;
         s2_mode_q  <= s1_mode_q;
      end
   end

   // ---------------- stage 3: combine and saturate ----------------
   logic signed [DW+1:0] a_ext;
   logic signed [DW+1:0] b_ext;
   logic signed [DW+1:0] comb_sum;
   logic [DW-1:0]        out_data_d;
   logic                 out_sat_d;
   logic                 out_valid_q;
   logic [DW-1:0]        out_data_q;
   logic                 out_sat_q;

   // full-precision combine, then clip to the DW-bit signed range
   always_comb begin
      a_ext = {s2_i_q[DW], s2_i_q};
      b_ext = {s2_q_q[DW], s2_q_q};
      case (s2_mode_q)
         MODE_SUM:    comb_sum = a_ext + b_ext;
         MODE_DIFF:   comb_sum = a_ext - b_ext;
         MODE_I_ONLY: comb_sum = a_ext;
         default:     comb_sum = b_ext;
      endcase
      out_sat_d  = 1'b0;
      out_data_d = comb_sum[DW-1:0];
      if (comb_sum > SAT_MAX) begin
         out_sat_d  = 1'b1;
         out_data_d = SAT_MAX[DW-1:0];
      end else if (comb_sum < SAT_MIN) begin
         out_sat_d  = 1'b1;
         out_data_d = SAT_MIN[DW-1:0];
      end
   end

   // output register; data and flag only update on a valid sample
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sat_q   <= 1'b0;
      end else begin
         out_valid_q <= s2_valid_q;
         if (s2_valid_q) begin
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_quad_mixer_pipe.sv
// Bench for quad_mixer_pipe: directed vectors plus random traffic, checked
// by a scoreboard fed from an arithmetic reference model.
module tb_quad_mixer_pipe;

   localparam int          DW       = 15;
   localparam int          GW       = 16;
   localparam logic [15:0] GAIN_RST = 16'h2861;
   localparam int          ONE      = 2 ** (GW - 1);
   localparam int          OUT_MAX  = 2 ** (DW - 1) - 1;
   localparam int          OUT_MIN  = -(2 ** (DW - 1));

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   logic rst_at_edge = 1'b1;

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cyc         <= cyc + 1;
      rst_at_edge <= reset;
   end

   // ---------------- DUT ----------------
   logic                 in_valid;
   logic signed [DW-1:0] in_i;
   logic signed [DW-1:0] in_q;
   logic                 lo_sel;
   logic [1:0]           lo_i_ext;
   logic [1:0]           lo_q_ext;
   logic                 lo_sync;
   logic [1:0]           lo_phase_init;
   logic [1:0]           mode;
   logic [GW-1:0]        gain;
   logic                 gain_load;
   logic                 out_valid;
   logic [DW-1:0]        out_data;
   logic                 out_sat;

   quad_mixer_pipe #(
      .DW       (DW),
      .GW       (GW),
      .GAIN_RST (GAIN_RST)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_i          (in_i),
      .in_q          (in_q),
      .lo_sel        (lo_sel),
      .lo_i_ext      (lo_i_ext),
      .lo_q_ext      (lo_q_ext),
      .lo_sync       (lo_sync),
      .lo_phase_init (lo_phase_init),
      .mode          (mode),
      .gain          (gain),
      .gain_load     (gain_load),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .out_sat       (out_sat)
   );

   // ---------------- scoreboard state ----------------
   logic [DW:0] exp_q[$];      // {sat, data}
   int          exp_cyc_q[$];  // cycle on which the sample must appear
   int          checks = 0;
   int          errors = 0;

   // reference model state
   int          p_m    = 0;
   int          gain_m = int'(GAIN_RST);
   int          tab_i[4] = '{1, 0, -1, 0};
   int          tab_q[4] = '{0, 1, 0, -1};
   logic        lit_en = 1'b0;
   logic [DW:0] lit_val = '0;

   function automatic int lo_val(input logic [1:0] c);
      if (c[1]) return -1;
      if (c[0]) return 1;
      return 0;
   endfunction

   function automatic int floor_div(input longint a, input longint d);
      longint q;
      q = a / d;
      if ((a % d != 0) && (a < 0)) q = q - 1;
      return int'(q);
   endfunction

   function automatic logic [DW:0] ref_out(input int x, input int y, input int li,
                                            input int lq, input int g, input int md);
      int   pi, pq, s;
      logic sat;
      pi = floor_div(longint'(x * li) * g, ONE);
      pq = floor_div(longint'(y * lq) * g, ONE);
      case (md)
         0:       s = pi + pq;
         1:       s = pi - pq;
         2:       s = pi;
         default: s = pq;
      endcase
      sat = 1'b0;
      if (s > OUT_MAX) begin
         s   = OUT_MAX;
         sat = 1'b1;
      end else if (s < OUT_MIN) begin
         s   = OUT_MIN;
         sat = 1'b1;
      end
      return {sat, s[DW-1:0]};
   endfunction

   // ---------------- driver tasks ----------------
   // Updates the model from the pins as currently driven, then clocks once.
   task automatic step();
      int          ph, li, lq;
      logic [DW:0] e;
      if (reset) begin
         p_m    = int'(lo_phase_init);
         gain_m = int'(GAIN_RST);
      end else begin
         if (gain_load) gain_m = int'(gain);
         if (in_valid) begin
            ph = lo_sync ? int'(lo_phase_init) : p_m;
            li = lo_sel ? tab_i[ph] : lo_val(lo_i_ext);
            lq = lo_sel ? tab_q[ph] : lo_val(lo_q_ext);
            e  = ref_out(int'(in_i), int'(in_q), li, lq, gain_m, int'(mode));
            exp_q.push_back(lit_en ? lit_val : e);
            exp_cyc_q.push_back(cyc + 3);
            p_m = (ph + 1) % 4;
         end else if (lo_sync) begin
            p_m = int'(lo_phase_init);
         end
      end
      lit_en = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic expect_lit(input int v, input logic s);
      lit_en  = 1'b1;
      lit_val = {s, v[DW-1:0]};
   endtask

   task automatic idle(input int n);
      in_valid  = 1'b0;
      lo_sync   = 1'b0;
      gain_load = 1'b0;
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic load_gain(input logic [GW-1:0] g);
      gain      = g;
      gain_load = 1'b1;
      in_valid  = 1'b0;
      step();
      gain_load = 1'b0;
   endtask

   task automatic sample(input int x, input int y);
      in_valid = 1'b1;
      in_i     = x[DW-1:0];
      in_q     = y[DW-1:0];
      step();
      in_valid = 1'b0;
      lo_sync  = 1'b0;
      gain_load = 1'b0;
   endtask

   // ---------------- monitor ----------------
   logic [DW-1:0] hold_d = '0;
   logic          hold_s = 1'b0;

   always @(negedge clock) begin
      logic [DW:0] e;
      int          ec;
      if (rst_at_edge) begin
         checks++;
         if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b data=%0d sat=%b, expected 0/0/0",
                     out_valid, $signed(out_data), out_sat);
         end
         hold_d = '0;
         hold_s = 1'b0;
      end else if (out_valid === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: out_valid=1 at cycle %0d with nothing expected", cyc);
         end else begin
            e  = exp_q.pop_front();
            ec = exp_cyc_q.pop_front();
            if ({out_sat, out_data} !== e || cyc != ec) begin
               errors++;
               $display("FAIL sample: got data=%0d sat=%b at cycle %0d, expected data=%0d sat=%b at cycle %0d",
                        $signed(out_data), out_sat, cyc, $signed(e[DW-1:0]), e[DW], ec);
            end
            hold_d = e[DW-1:0];
            hold_s = e[DW];
         end
      end else begin
         checks++;
         if (out_valid !== 1'b0 || out_data !== hold_d || out_sat !== hold_s) begin
            errors++;
            $display("FAIL hold: got valid=%b data=%0d sat=%b, expected valid=0 data=%0d sat=%b",
                     out_valid, $signed(out_data), out_sat, $signed(hold_d), hold_s);
         end
         if (exp_q.size() != 0 && exp_cyc_q[0] < cyc) begin
            errors++;
            $display("FAIL missing_valid: sample due at cycle %0d not seen by cycle %0d",
                     exp_cyc_q[0], cyc);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int wait_cyc;
      int x, y;
      in_valid      = 1'b0;
      in_i          = '0;
      in_q          = '0;
      lo_sel        = 1'b0;
      lo_i_ext      = 2'b00;
      lo_q_ext      = 2'b00;
      lo_sync       = 1'b0;
      lo_phase_init = 2'd0;
      mode          = 2'b00;
      gain          = '0;
      gain_load     = 1'b0;

      // reset
      reset = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(2);

      // external LO, gain 0.5: 500 + 100
      load_gain(16'h4000);
      lo_sel = 1'b0; lo_i_ext = 2'b01; lo_q_ext = 2'b01; mode = 2'b00;
      expect_lit(600, 1'b0);
      sample(1000, 200);
      idle(4);

      // saturation: each path 16382, sum clips
      load_gain(16'h7FFF);
      expect_lit(16383, 1'b1);
      sample(16383, 16383);
      idle(4);

      // negation of the most negative input, both -1 encodings
      load_gain(16'h8000);
      lo_i_ext = 2'b10; lo_q_ext = 2'b01; mode = 2'b10;
      expect_lit(16383, 1'b1);
      sample(-16384, 123);
      lo_i_ext = 2'b11;
      expect_lit(16383, 1'b1);
      sample(-16384, -5);
      idle(4);

      // internal LO from phase 0, then sync to 2 with a sample
      lo_sel = 1'b1; mode = 2'b00;
      lo_phase_init = 2'd0; lo_sync = 1'b1;
      idle(0);
      step();
      lo_sync = 1'b0;
      expect_lit(100, 1'b0);  sample(100, 50);
      expect_lit(50, 1'b0);   sample(100, 50);
      expect_lit(-100, 1'b0); sample(100, 50);
      expect_lit(-50, 1'b0);  sample(100, 50);
      expect_lit(100, 1'b0);  sample(100, 50);
      lo_sync = 1'b1; lo_phase_init = 2'd2;
      expect_lit(-100, 1'b0); sample(100, 50);
      expect_lit(-50, 1'b0);  sample(100, 50);
      idle(4);

      // gain change between back-to-back samples
      lo_sel = 1'b0; lo_i_ext = 2'b01; lo_q_ext = 2'b00; mode = 2'b10;
      expect_lit(1000, 1'b0); sample(1000, 0);
      expect_lit(1000, 1'b0); sample(1000, 0);
      gain = 16'h4000; gain_load = 1'b1;
      expect_lit(500, 1'b0);  sample(1000, 0);
      expect_lit(500, 1'b0);  sample(1000, 0);
      idle(4);

      // reset with two samples in flight: both are dropped
      sample(321, 0);
      sample(-321, 0);
      reset = 1'b1;
      exp_q.delete();
      exp_cyc_q.delete();
      idle(2);
      reset = 1'b0;
      idle(4);
      // first sample after reset runs at the reset gain: floor(1000*10337/32768)
      expect_lit(315, 1'b0);
      sample(1000, 0);
      idle(4);

      // random traffic
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            x = ($urandom_range(0, 1) == 1) ? OUT_MAX : OUT_MIN;
         end else begin
            x = int'($urandom_range(0, 32767)) - 16384;
         end
         y = int'($urandom_range(0, 32767)) - 16384;
         in_valid      = ($urandom_range(0, 3) != 0);
         in_i          = x[DW-1:0];
         in_q          = y[DW-1:0];
         lo_sel        = 1'($urandom_range(0, 1));
         lo_i_ext      = 2'($urandom_range(0, 3));
         lo_q_ext      = 2'($urandom_range(0, 3));
         mode          = 2'($urandom_range(0, 3));
         lo_sync       = ($urandom_range(0, 15) == 0);
         lo_phase_init = 2'($urandom_range(0, 3));
         gain_load     = ($urandom_range(0, 9) == 0);
         gain          = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
         step();
      end
      idle(0);
      in_valid = 1'b0; lo_sync = 1'b0; gain_load = 1'b0;

      // drain with a bound
      wait_cyc = 0;
      while (exp_q.size() != 0 && wait_cyc < 20) begin
         step();
         wait_cyc++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d samples still outstanding, expected 0", exp_q.size());
      end
      idle(3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/quad_mixer_pipe.md
QUAD_MIXER_PIPE -- requirements
Module: quad_mixer_pipe

Interface
REQ-001 Parameter DW, default 15: signed I/Q input and output sample width.
REQ-002 Parameter GW, default 16: unsigned gain width, format Q1.(GW-1); 1.0 is 2^(GW-1).
REQ-003 Parameter GAIN_RST, default 16'h2861: active gain after reset (about 0.3155).
REQ-004 clock  in  1  system clock; all state changes on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  1  a sample is present on in_i/in_q this cycle; there is no backpressure.
REQ-007 in_i, in_q  in  DW each  signed I and Q input samples.
REQ-008 lo_sel  in  1  0 = external LO, 1 = internal fs/4 LO.
REQ-009 lo_i_ext, lo_q_ext  in  2 each  external LO; 2'b1x = -1, 2'b01 = +1, 2'b00 = 0.
REQ-010 lo_sync  in  1  pulse; reloads the internal LO phase from lo_phase_init.
REQ-011 lo_phase_init  in  2  starting phase of the internal LO.
REQ-012 mode  in  2  output combine: 00 = I+Q, 01 = I-Q, 10 = I only, 11 = Q only.
REQ-013 gain, gain_load  in  GW, 1  new gain value and its load strobe.
REQ-014 out_valid  out  1  out_data is valid this cycle.
REQ-015 out_data  out  DW  signed mixed output sample.
REQ-016 out_sat  out  1  saturation occurred on this output sample.

Function
REQ-017 Latency is fixed at 3 cycles: out_valid equals in_valid delayed 3 cycles.
REQ-018 Stage 1 forms the LO-weighted values: x times lo_i for I and y times lo_q for Q, each DW+1 bits with no wrap.
- Negating -2^(DW-1) gives +2^(DW-1).
REQ-019 Stage 2 multiplies each stage-1 value by the active gain.
- The product is arithmetically shifted right by GW-1, so it truncates toward minus infinity.
REQ-020 Stage 3 combines the stage-2 values per mode at full precision (DW+2 bits).
- It then saturates to [-2^(DW-1), 2^(DW-1)-1].
- out_sat is 1 exactly when clipping occurred on that sample.
REQ-021 Internal LO phase p advances by 1 (mod 4) on each accepted sample (in_valid=1) only.
- lo_i sequence over p = 0..3: +1, 0, -1, 0.
- lo_q sequence over p = 0..3: 0, +1, 0, -1.
REQ-022 The phase used for a sample is the phase held before that sample's advance.
REQ-023 lo_sync takes priority over advance: when lo_sync=1, p loads lo_phase_init.
- If in_valid is also 1, that sample uses lo_phase_init and p becomes lo_phase_init+1.
REQ-024 When lo_sel=0, the external LO is sampled in the same cycle as its data sample, and p still advances.
REQ-025 On gain_load=1, gain is captured into the active gain register.
- The new gain applies to samples entering stage 2 in the following cycle or later.
- Samples already in stage 2 keep the old gain.
REQ-026 mode and lo_sel are sampled together with each sample at stage 1 and pipelined with it.
- A change therefore never affects samples already in flight.
REQ-027 When out_valid=0, out_data and out_sat hold their last values.
REQ-028 Pipeline stages advance every cycle whatever in_valid is; only the valid bits gate the phase counter and the output update.

Reset
REQ-029 During reset the following values apply:
- out_valid, out_data and out_sat are 0.
- All valid pipeline bits are 0.
- p equals lo_phase_init.
- The active gain equals GAIN_RST.
REQ-030 A reset in mid-stream discards in-flight samples, with no out_valid pulse on the cycle after reset deasserts.
REQ-031 The first sample after reset appears 3 cycles after acceptance.

Structure
REQ-032 Shared package mixer_pkg holds:
- the LO code constants (LO_NEG, LO_POS, LO_ZERO);
- the mode enumeration;
- the internal LO tables.
REQ-033 The internal phase counter and its LO tables are a sub-module named quad_lo_gen, with clock, reset, advance, sync, phase_init, lo_i and lo_q ports.

Verification
REQ-034 External LO check.
- Stimulus: DW=15, gain 16'h4000 loaded, lo_sel=0, lo_i=lo_q=+1, mode 00, in_i=1000, in_q=200.
- Response: out_data 600, 3 cycles later.
REQ-035 Saturation check.
- Stimulus: gain 16'h7FFF, in_i=in_q=16383, lo=+1/+1, mode 00.
- Response: out_data 16383, out_sat=1; each path gives 16382 before the combine.
REQ-036 Negation check.
- Stimulus: gain 16'h8000, in_i=-16384, lo_i=-1, mode 10.
- Response: out_data 16383, out_sat=1.
REQ-037 Internal LO check.
- Stimulus: lo_sel=1, lo_phase_init=0, gain 16'h8000, mode 00, constant in_i=100, in_q=50, 5 back-to-back samples.
- Response: out_data 100, 50, -100, -50, 100.
- Follow-up: lo_sync with init 2 concurrent with a sample; that sample gives -100.
REQ-038 Gain and reset timing check.
- Stimulus: change gain between back-to-back samples, and assert reset with 2 samples in flight.
- Response: the gain switches on the exact sample set by REQ-025; after reset, no out_valid appears for the dropped samples.
